// File: rtl/rv_i2c_target.sv
// Single-address I2C target: filters the bus, decodes START/STOP, ACKs its address
// and moves bytes through rx/tx valid/ready streams, stretching SCL when stalled.
module rv_i2c_target #(
    parameter logic [6:0]  ADDRESS       = 7'h42,
    parameter int unsigned FILTER_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    output logic       scl_t,
    output logic       scl_o,
    input  logic       sda_i,
    output logic       sda_t,
    output logic       sda_o,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_first,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    output logic       busy,
    output logic       stop_pulse
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_LOAD, RD_DATA, RD_ACK, WAIT_STOP
    } state_e;

    localparam int unsigned CW = $clog2(FILTER_CYCLES + 1);

    // Index 0 carries SCL, index 1 carries SDA through sync, filter and edge stages.
    logic [1:0]    sync1_q, sync1_d, sync2_q, sync2_d, filt_q, filt_d, prev_q, prev_d;
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];

    state_e      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d, tx_shift_q, tx_shift_d, rx_data_q, rx_data_d;
    logic        rw_q, rw_d, first_q, first_d, rx_valid_q, rx_valid_d;
    logic        rx_first_q, rx_first_d, busy_q, busy_d, stop_pulse_q, stop_pulse_d;
    logic        sda_drive_q, sda_drive_d, scl_hold_q, scl_hold_d;
    logic        scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, rx_free;

    always_comb begin
        sync1_d = {sda_i, scl_i};
        sync2_d = sync1_q;
        prev_d  = filt_q;
        for (int i = 0; i < 2; i++) begin
            filt_d[i] = filt_q[i];
            cnt_d[i]  = '0;
            if (sync2_q[i] != filt_q[i]) begin
                if (cnt_q[i] == CW'(FILTER_CYCLES - 1)) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign scl_f     = filt_q[0];
    assign sda_f     = filt_q[1];
    assign scl_rise  = scl_f & ~prev_q[0];
    assign scl_fall  = ~scl_f & prev_q[0];
    assign start_det = scl_f & prev_q[1] & ~sda_f;
    assign stop_det  = scl_f & ~prev_q[1] & sda_f;
    assign rx_free   = ~rx_valid_q | rx_ready;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        tx_shift_d   = tx_shift_q;
        rx_data_d    = rx_data_q;
        rw_d         = rw_q;
        first_d      = first_q;
        rx_valid_d   = rx_valid_q & ~rx_ready;
        rx_first_d   = rx_first_q;
        busy_d       = busy_q;
        stop_pulse_d = 1'b0;
        sda_drive_d  = sda_drive_q;
        scl_hold_d   = scl_hold_q;
        tx_ready     = 1'b0;

        case (state_q)
            ADDR: begin
                if (scl_rise) begin
                    shift_d   = {shift_q[6:0], sda_f};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end else if (scl_fall && bit_cnt_q == 4'd8) begin
                    if (shift_q[7:1] == ADDRESS) begin
                        sda_drive_d = 1'b1;
                        busy_d      = 1'b1;
                        first_d     = 1'b1;
                        rw_d        = shift_q[0];
                        state_d     = ADDR_ACK;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = WAIT_STOP;
                    end
                end
            end
            ADDR_ACK: begin
                if (scl_fall) begin
                    sda_drive_d = 1'b0;
                    bit_cnt_d   = 4'd0;
                    state_d     = rw_q ? RD_LOAD : WR_DATA;
                end
            end
            WR_DATA: begin
                if (scl_rise) begin
                    shift_d   = {shift_q[6:0], sda_f};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end else if ((scl_fall && bit_cnt_q == 4'd8) || scl_hold_q) begin
                    // Stretch until the consumer frees the holding register.
                    if (rx_free) begin
                        rx_data_d   = shift_q;
                        rx_valid_d  = 1'b1;
                        rx_first_d  = first_q;
                        first_d     = 1'b0;
                        sda_drive_d = 1'b1;
                        scl_hold_d  = 1'b0;
                        state_d     = WR_ACK;
                    end else begin
                        scl_hold_d = 1'b1;
                    end
                end
            end
            WR_ACK: begin
                if (scl_fall) begin
                    sda_drive_d = 1'b0;
                    bit_cnt_d   = 4'd0;
                    state_d     = WR_DATA;
                end
            end
            RD_LOAD: begin
                if (tx_valid) begin
                    tx_ready    = 1'b1;
                    tx_shift_d  = tx_data;
                    sda_drive_d = ~tx_data[7];
                    scl_hold_d  = 1'b0;
                    bit_cnt_d   = 4'd0;
                    state_d     = RD_DATA;
                end else begin
                    scl_hold_d = 1'b1;
                end
            end
            RD_DATA: begin
                if (scl_rise) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end else if (scl_fall) begin
                    if (bit_cnt_q == 4'd8) begin
                        sda_drive_d = 1'b0;
                        bit_cnt_d   = 4'd0;
                        state_d     = RD_ACK;
                    end else begin
                        tx_shift_d  = {tx_shift_q[6:0], 1'b0};
                        sda_drive_d = ~tx_shift_q[6];
                    end
                end
            end
            RD_ACK: begin
                if (scl_rise) begin
                    if (sda_f) begin
                        state_d = WAIT_STOP;
                    end else begin
                        bit_cnt_d = 4'd1;
                    end
                end else if (scl_fall && bit_cnt_q == 4'd1) begin
                    state_d = RD_LOAD;
                end
            end
            default: ;
        endcase

        if (start_det) begin
            state_d     = ADDR;
            bit_cnt_d   = 4'd0;
            sda_drive_d = 1'b0;
            scl_hold_d  = 1'b0;
            tx_ready    = 1'b0;
        end else if (stop_det) begin
            state_d      = IDLE;
            sda_drive_d  = 1'b0;
            scl_hold_d   = 1'b0;
            tx_ready     = 1'b0;
            busy_d       = 1'b0;
            stop_pulse_d = busy_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= 2'b11;
            sync2_q      <= 2'b11;
            filt_q       <= 2'b11;
            prev_q       <= 2'b11;
            cnt_q[0]     <= '0;
            cnt_q[1]     <= '0;
            state_q      <= IDLE;
            bit_cnt_q    <= 4'd0;
            shift_q      <= 8'd0;
            tx_shift_q   <= 8'd0;
            rx_data_q    <= 8'd0;
            rw_q         <= 1'b0;
            first_q      <= 1'b0;
            rx_valid_q   <= 1'b0;
            rx_first_q   <= 1'b0;
            busy_q       <= 1'b0;
            stop_pulse_q <= 1'b0;
            sda_drive_q  <= 1'b0;
            scl_hold_q   <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            filt_q       <= filt_d;
            prev_q       <= prev_d;
            cnt_q[0]     <= cnt_d[0];
            cnt_q[1]     <= cnt_d[1];
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            tx_shift_q   <= tx_shift_d;
            rx_data_q    <= rx_data_d;
            rw_q         <= rw_d;
            first_q      <= first_d;
            rx_valid_q   <= rx_valid_d;
            rx_first_q   <= rx_first_d;
            busy_q       <= busy_d;
            stop_pulse_q <= stop_pulse_d;
            sda_drive_q  <= sda_drive_d;
            scl_hold_q   <= scl_hold_d;
        end
    end

    assign scl_t      = ~scl_hold_q;
    assign scl_o      = 1'b0;
    assign sda_t      = ~sda_drive_q;
    assign sda_o      = 1'b0;
    assign rx_valid   = rx_valid_q;
    assign rx_data    = rx_data_q;
    assign rx_first   = rx_first_q;
    assign busy       = busy_q;
    assign stop_pulse = stop_pulse_q;

endmodule

// File: tb/tb_rv_i2c_target.sv
// Directed bench for rv_i2c_target: a bit-banged I2C controller with open-drain
// line model, stream monitors and immediate-assertion checks.
module tb_rv_i2c_target;

    localparam int Q = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclM, sdaM;
    logic       sclLine, sdaLine;
    logic       sclT, sclO, sdaT, sdaO;
    logic       rxValid, rxReady, rxFirst, txValid, txReady, busy, stopPulse;
    logic [7:0] rxData, txData;

    int checks   = 0;
    int failures = 0;
    int txReadyCnt = 0;
    int stopCnt    = 0;
    int sdaLowCnt  = 0;
    logic [7:0] rxLog[$];
    logic       rxFirstLog[$];

    always #5 clk = ~clk;

    assign sclLine = sclM & (sclT | sclO);
    assign sdaLine = sdaM & (sdaT | sdaO);

    rv_i2c_target dut (
        .clk(clk), .rst(rst),
        .scl_i(sclLine), .scl_t(sclT), .scl_o(sclO),
        .sda_i(sdaLine), .sda_t(sdaT), .sda_o(sdaO),
        .rx_valid(rxValid), .rx_ready(rxReady), .rx_data(rxData), .rx_first(rxFirst),
        .tx_valid(txValid), .tx_ready(txReady), .tx_data(txData),
        .busy(busy), .stop_pulse(stopPulse)
    );

    // Stream and pulse monitors sample on the falling edge, where everything is stable.
    always @(negedge clk) begin
        if (rxValid && rxReady) begin
            rxLog.push_back(rxData);
            rxFirstLog.push_back(rxFirst);
        end
        if (txReady) txReadyCnt++;
        if (stopPulse) stopCnt++;
        if (!sdaT) sdaLowCnt++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic rdy, input logic tv, input logic [7:0] td);
        rxReady = rdy;
        txValid = tv;
        txData  = td;
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic releaseScl();
        sclM = 1'b1;
        for (int i = 0; i < 2000 && sclLine !== 1'b1; i++) waitClk(1);
        checkOutput("scl_release", sclLine, 1);
    endtask

    task automatic writeBit(input logic b, output logic s);
        sdaM = b;
        waitClk(Q);
        releaseScl();
        waitClk(Q);
        s = sdaLine;
        waitClk(Q);
        sclM = 1'b0;
        waitClk(Q);
    endtask

    task automatic sendBits(input logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) writeBit(d[i], s);
    endtask

    task automatic writeByte(input logic [7:0] d, output logic ack);
        sendBits(d);
        writeBit(1'b1, ack);
    endtask

    task automatic readByte(output logic [7:0] d, input logic nack);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            writeBit(1'b1, s);
            d[i] = s;
        end
        writeBit(nack, s);
    endtask

    task automatic i2cStart();
        sdaM = 1'b1;
        waitClk(Q);
        releaseScl();
        waitClk(Q);
        sdaM = 1'b0;
        waitClk(Q);
        sclM = 1'b0;
        waitClk(Q);
    endtask

    task automatic i2cStop();
        sdaM = 1'b0;
        waitClk(Q);
        releaseScl();
        waitClk(Q);
        sdaM = 1'b1;
        waitClk(Q);
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd;
        int         rxBase, stopBase, txBase, sdaBase;

        rst  = 1'b1;
        sclM = 1'b1;
        sdaM = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'h00);
        waitClk(3);
        checkOutput("rst_scl_t", sclT, 1);
        checkOutput("rst_sda_t", sdaT, 1);
        checkOutput("rst_rx_valid", rxValid, 0);
        checkOutput("rst_rx_first", rxFirst, 0);
        checkOutput("rst_tx_ready", txReady, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_stop_pulse", stopPulse, 0);
        rst = 1'b0;
        waitClk(10);

        // Plain write of two bytes to our address.
        rxBase = rxLog.size();
        stopBase = stopCnt;
        i2cStart();
        writeByte(8'h84, ack);
        checkOutput("t1_addr_ack", ack, 0);
        checkOutput("t1_busy", busy, 1);
        writeByte(8'hA5, ack);
        checkOutput("t1_ack_a5", ack, 0);
        writeByte(8'h3C, ack);
        checkOutput("t1_ack_3c", ack, 0);
        i2cStop();
        waitClk(10);
        checkOutput("t1_stop_pulses", stopCnt - stopBase, 1);
        checkOutput("t1_busy_after", busy, 0);
        checkOutput("t1_rx_count", rxLog.size() - rxBase, 2);
        if (rxLog.size() >= rxBase + 2) begin
            checkOutput("t1_rx0", rxLog[rxBase], 8'hA5);
            checkOutput("t1_first0", rxFirstLog[rxBase], 1);
            checkOutput("t1_rx1", rxLog[rxBase+1], 8'h3C);
            checkOutput("t1_first1", rxFirstLog[rxBase+1], 0);
        end

        // Foreign address: the target must stay silent.
        rxBase = rxLog.size();
        stopBase = stopCnt;
        sdaBase = sdaLowCnt;
        i2cStart();
        writeByte(8'h86, ack);
        checkOutput("t2_nack", ack, 1);
        checkOutput("t2_busy", busy, 0);
        i2cStop();
        waitClk(10);
        checkOutput("t2_sda_never_low", sdaLowCnt - sdaBase, 0);
        checkOutput("t2_no_stop_pulse", stopCnt - stopBase, 0);
        checkOutput("t2_no_rx", rxLog.size() - rxBase, 0);
        checkOutput("t2_rx_valid", rxValid, 0);

        // Read with a late tx_valid, then controller NACK.
        stopBase = stopCnt;
        txBase = txReadyCnt;
        applyStimulus(1'b1, 1'b0, 8'h96);
        i2cStart();
        writeByte(8'h85, ack);
        checkOutput("t3_addr_ack", ack, 0);
        checkOutput("t3_stretch", sclT, 0);
        applyStimulus(1'b1, 1'b1, 8'h96);
        waitClk(3);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("t3_scl_released", sclT, 1);
        readByte(rd, 1'b1);
        checkOutput("t3_read_data", rd, 8'h96);
        checkOutput("t3_tx_ready_pulses", txReadyCnt - txBase, 1);
        checkOutput("t3_sda_released", sdaT, 1);
        checkOutput("t3_scl_idle", sclT, 1);
        checkOutput("t3_busy_until_stop", busy, 1);
        i2cStop();
        waitClk(10);
        checkOutput("t3_stop_pulses", stopCnt - stopBase, 1);
        checkOutput("t3_busy_after", busy, 0);

        // Stalled consumer: second byte stretches SCL until rx_ready rises.
        applyStimulus(1'b0, 1'b0, 8'h00);
        rxBase = rxLog.size();
        i2cStart();
        writeByte(8'h84, ack);
        checkOutput("t4_addr_ack", ack, 0);
        writeByte(8'h11, ack);
        checkOutput("t4_ack_11", ack, 0);
        checkOutput("t4_rx_valid", rxValid, 1);
        checkOutput("t4_rx_data", rxData, 8'h11);
        checkOutput("t4_rx_first", rxFirst, 1);
        sendBits(8'h22);
        checkOutput("t4_stretch", sclT, 0);
        waitClk(50);
        checkOutput("t4_still_stretched", sclT, 0);
        checkOutput("t4_hold_data", rxData, 8'h11);
        applyStimulus(1'b1, 1'b0, 8'h00);
        writeBit(1'b1, ack);
        checkOutput("t4_ack_22", ack, 0);
        i2cStop();
        waitClk(10);
        checkOutput("t4_rx_count", rxLog.size() - rxBase, 2);
        if (rxLog.size() >= rxBase + 2) begin
            checkOutput("t4_rx0", rxLog[rxBase], 8'h11);
            checkOutput("t4_first0", rxFirstLog[rxBase], 1);
            checkOutput("t4_rx1", rxLog[rxBase+1], 8'h22);
            checkOutput("t4_first1", rxFirstLog[rxBase+1], 0);
        end

        // Write, repeated START, then read.
        rxBase = rxLog.size();
        txBase = txReadyCnt;
        applyStimulus(1'b1, 1'b0, 8'h00);
        i2cStart();
        writeByte(8'h84, ack);
        checkOutput("t5_waddr_ack", ack, 0);
        writeByte(8'h55, ack);
        checkOutput("t5_ack_55", ack, 0);
        applyStimulus(1'b1, 1'b1, 8'hC3);
        i2cStart();
        writeByte(8'h85, ack);
        checkOutput("t5_raddr_ack", ack, 0);
        readByte(rd, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("t5_read_data", rd, 8'hC3);
        checkOutput("t5_tx_ready_pulses", txReadyCnt - txBase, 1);
        i2cStop();
        waitClk(10);
        checkOutput("t5_rx_count", rxLog.size() - rxBase, 1);
        if (rxLog.size() >= rxBase + 1) begin
            checkOutput("t5_rx0", rxLog[rxBase], 8'h55);
            checkOutput("t5_first0", rxFirstLog[rxBase], 1);
        end

        // Two-clock SDA glitch while SCL is high must not start a transfer.
        stopBase = stopCnt;
        sdaM = 1'b0;
        waitClk(1);
        sclM = 1'b0;
        waitClk(1);
        sdaM = 1'b1;
        waitClk(Q);
        sendBits(8'h84);
        writeBit(1'b1, ack);
        checkOutput("t6_glitch_no_ack", ack, 1);
        checkOutput("t6_glitch_busy", busy, 0);
        i2cStop();
        waitClk(10);
        checkOutput("t6_glitch_no_stop", stopCnt - stopBase, 0);

        // Asynchronous reset in the middle of a read releases both lines immediately.
        applyStimulus(1'b1, 1'b1, 8'h00);
        i2cStart();
        writeByte(8'h85, ack);
        checkOutput("t6_raddr_ack", ack, 0);
        waitClk(5);
        checkOutput("t6_sda_driven", sdaT, 0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6_rst_sda_t", sdaT, 1);
        checkOutput("t6_rst_scl_t", sclT, 1);
        checkOutput("t6_rst_busy", busy, 0);
        applyStimulus(1'b1, 1'b0, 8'h00);
        sclM = 1'b1;
        sdaM = 1'b1;
        waitClk(3);
        rst = 1'b0;
        waitClk(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
